// File: rtl/pcpi_seq_mul_if.sv
// PCPI bundle between the core (master) and a coprocessor (slave).
// Carries the offered instruction, operands and the write-back response.
interface pcpi_seq_mul_if;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;

  modport master (
    output pcpi_valid,
    output pcpi_insn,
    output pcpi_rs1,
    output pcpi_rs2,
    input  pcpi_wr,
    input  pcpi_rd,
    input  pcpi_wait,
    input  pcpi_ready
  );

  modport slave (
    input  pcpi_valid,
    input  pcpi_insn,
    input  pcpi_rs1,
    input  pcpi_rs2,
    output pcpi_wr,
    output pcpi_rd,
    output pcpi_wait,
    output pcpi_ready
  );
endinterface

// File: rtl/pcpi_seq_mul.sv
// Iterative shift-add RV32M multiplier on the PCPI responder side.
// Define PCPI_SEQ_MUL_MULH_EN to claim MULH/MULHSU/MULHU (64-bit path).
module pcpi_seq_mul #(
  parameter int STEPS_PER_CYCLE = 1
) (
  input logic            clk,
  input logic            resetn,
  pcpi_seq_mul_if.slave  pcpi
);

`ifdef PCPI_SEQ_MUL_MULH_EN
  localparam int W = 64;
`else
  localparam int W = 32;
`endif

  localparam logic [6:0] STEP = 7'(STEPS_PER_CYCLE);

  if (!(STEPS_PER_CYCLE == 1 || STEPS_PER_CYCLE == 2 ||
        STEPS_PER_CYCLE == 4 || STEPS_PER_CYCLE == 8)) begin : g_bad_steps
    $error("STEPS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [W-1:0] acc;
  logic [W-1:0] mcand;
  logic [W-1:0] mplier;
  logic [W-1:0] acc_nx;
  logic [W-1:0] mcand_nx;
  logic [W-1:0] mplier_nx;
  logic [W-1:0] a_op;
  logic [W-1:0] b_op;
  logic [6:0]   cnt;
  logic [6:0]   n_ld;
  logic         rdy_q;
  logic [31:0]  rd_q;
  logic [31:0]  res;
  logic [2:0]   f3;
  logic         is_op;
  logic         match;
  logic         accept;
  logic         unused;

  assign f3    = pcpi.pcpi_insn[14:12];
  assign is_op = (pcpi.pcpi_insn[6:0] == 7'b0110011) &&
                 (pcpi.pcpi_insn[31:25] == 7'b0000001);
  assign unused = ^{pcpi.pcpi_insn[24:15], pcpi.pcpi_insn[11:7]};

`ifdef PCPI_SEQ_MUL_MULH_EN
  logic hi;

  assign match = is_op && !f3[2];

  always_comb begin
    a_op = {{32{pcpi.pcpi_rs1[31] &
                (f3 == 3'b001 || f3 == 3'b010)}},
            pcpi.pcpi_rs1};
    b_op = {{32{pcpi.pcpi_rs2[31] & (f3 == 3'b001)}},
            pcpi.pcpi_rs2};
    n_ld = (f3 == 3'b000) ? 7'd32 : 7'd64;
  end

  assign res = hi ? acc_nx[63:32] : acc_nx[31:0];
`else
  assign match = is_op && (f3 == 3'b000);

  always_comb begin
    a_op = pcpi.pcpi_rs1;
    b_op = pcpi.pcpi_rs2;
    n_ld = 7'd32;
  end

  assign res = acc_nx;
`endif

  assign accept = pcpi.pcpi_valid && match && !rdy_q;

  always_comb begin
    acc_nx    = acc;
    mcand_nx  = mcand;
    mplier_nx = mplier;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (mplier_nx[0]) acc_nx = acc_nx + mcand_nx;
      mcand_nx  = mcand_nx << 1;
      mplier_nx = mplier_nx >> 1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = RUN;
      RUN: begin
        if (!pcpi.pcpi_valid)  state_nx = IDLE;
        else if (cnt == STEP)  state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // rdy_q blocks re-accepting the instruction the core is still retiring
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      rdy_q  <= 1'b0;
      rd_q   <= '0;
`ifdef PCPI_SEQ_MUL_MULH_EN
      hi     <= 1'b0;
`endif
    end else begin
      rdy_q <= (state == DONE);
      if (state == IDLE && accept) begin
        acc    <= '0;
        mcand  <= a_op;
        mplier <= b_op;
        cnt    <= n_ld;
`ifdef PCPI_SEQ_MUL_MULH_EN
        hi     <= (f3 != 3'b000);
`endif
      end else if (state == RUN) begin
        acc    <= acc_nx;
        mcand  <= mcand_nx;
        mplier <= mplier_nx;
        cnt    <= cnt - STEP;
      end
      if (state == RUN && state_nx == DONE) rd_q <= res;
    end
  end

  assign pcpi.pcpi_wait  = (state == RUN);
  assign pcpi.pcpi_ready = (state == DONE);
  assign pcpi.pcpi_wr    = (state == DONE);
  assign pcpi.pcpi_rd    = rd_q;

endmodule

// File: tb/tb_pcpi_seq_mul.sv
// Bench for pcpi_seq_mul: STEPS=1 and STEPS=4 instances, vector table,
// scoreboard of expected results, abort/reset/guard sequences.
module tb_pcpi_seq_mul;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pcpi_seq_mul_if b1 ();
  pcpi_seq_mul_if b4 ();

  pcpi_seq_mul #(.STEPS_PER_CYCLE(1)) u1 (
    .clk(clk), .resetn(resetn), .pcpi(b1.slave));
  pcpi_seq_mul #(.STEPS_PER_CYCLE(4)) u4 (
    .clk(clk), .resetn(resetn), .pcpi(b4.slave));

  typedef struct {
    int          sel;
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    bit          claim;
    logic [31:0] rd;
    int          n;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    int          lat;
  } exp_t;

  vec_t vt[$];
  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  localparam logic [31:0] I_MUL    = 32'h022081B3;
  localparam logic [31:0] I_MULH   = 32'h022091B3;
  localparam logic [31:0] I_MULHSU = 32'h0220A1B3;
  localparam logic [31:0] I_MULHU  = 32'h0220B1B3;
  localparam logic [31:0] I_DIV    = 32'h0220C1B3;
  localparam logic [31:0] I_ADD    = 32'h002081B3;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v,
                       input logic [31:0] insn,
                       input logic [31:0] a,
                       input logic [31:0] b);
    if (sel == 0) begin
      b1.pcpi_valid = v; b1.pcpi_insn = insn;
      b1.pcpi_rs1 = a;   b1.pcpi_rs2 = b;
    end else begin
      b4.pcpi_valid = v; b4.pcpi_insn = insn;
      b4.pcpi_rs1 = a;   b4.pcpi_rs2 = b;
    end
  endtask

  function automatic logic get_ready(input int sel);
    return (sel == 0) ? b1.pcpi_ready : b4.pcpi_ready;
  endfunction
  function automatic logic get_wait(input int sel);
    return (sel == 0) ? b1.pcpi_wait : b4.pcpi_wait;
  endfunction
  function automatic logic get_wr(input int sel);
    return (sel == 0) ? b1.pcpi_wr : b4.pcpi_wr;
  endfunction
  function automatic logic [31:0] get_rd(input int sel);
    return (sel == 0) ? b1.pcpi_rd : b4.pcpi_rd;
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] a64, b64, p;
    a64 = {32'd0, a};
    b64 = {32'd0, b};
    if ((f3 == 3'b001 || f3 == 3'b010) && a[31]) a64[63:32] = '1;
    if (f3 == 3'b001 && b[31]) b64[63:32] = '1;
    p = a64 * b64;
    return (f3 == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  function automatic vec_t mk(input int sel, input logic [31:0] insn,
                              input logic [31:0] a, input logic [31:0] b,
                              input bit claim, input logic [31:0] rd);
    vec_t v;
    logic [2:0] f3;
    f3 = insn[14:12];
    v.sel = sel; v.insn = insn; v.rs1 = a; v.rs2 = b;
    v.claim = claim; v.rd = rd;
    v.n = ((f3 == 3'b000) ? 32 : 64) / ((sel == 0) ? 1 : 4);
    return v;
  endfunction

  task automatic do_op(input vec_t v);
    int   lat;
    bit   got;
    bit   wait_ok;
    bit   quiet;
    exp_t e;
    drive(v.sel, 1'b1, v.insn, v.rs1, v.rs2);
    if (!v.claim) begin
      quiet = 1'b1;
      repeat (20) begin
        @(posedge clk); #1;
        if (get_wait(v.sel) || get_ready(v.sel) || get_wr(v.sel))
          quiet = 1'b0;
      end
      check("unclaimed_quiet", 32'(quiet), 32'd1);
      drive(v.sel, 1'b0, 32'd0, 32'd0, 32'd0);
      @(posedge clk); #1;
      return;
    end
    sbq.push_back('{rd: v.rd, lat: v.n + 1});
    wait_ok = 1'b1;
    got = 1'b0;
    lat = 0;
    while (!got && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (get_ready(v.sel)) got = 1'b1;
      else if (!get_wait(v.sel)) wait_ok = 1'b0;
    end
    check("ready_seen", 32'(got), 32'd1);
    check("wait_in_run", 32'(wait_ok), 32'd1);
    if (got) begin
      check("wait_low_done", 32'(get_wait(v.sel)), 32'd0);
      check("wr_with_ready", 32'(get_wr(v.sel)), 32'd1);
      if (sbq.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("rd", get_rd(v.sel), e.rd);
        check("latency", 32'(lat), 32'(e.lat));
      end
    end else if (sbq.size() != 0) begin
      e = sbq.pop_front();
    end
    @(posedge clk); #1;
    check("ready_one_cycle", 32'(get_ready(v.sel)), 32'd0);
    @(posedge clk); #1;
    check("guard_no_reaccept", 32'(get_wait(v.sel)), 32'd0);
    drive(v.sel, 1'b0, 32'd0, 32'd0, 32'd0);
    check("rd_hold", get_rd(v.sel), v.rd);
    @(posedge clk); #1;
  endtask

  task automatic quiet_window(input int sel, input int cycles,
                              input string name);
    bit q;
    q = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (get_ready(sel) || get_wait(sel) || get_wr(sel)) q = 1'b0;
    end
    check(name, 32'(q), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  f;
    logic [31:0] abort_insn;

    drive(0, 1'b0, 32'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 32'd0, 32'd0, 32'd0);

    vt.push_back(mk(0, I_MUL, 32'd7, 32'hFFFFFFFD, 1, 32'hFFFFFFEB));
    vt.push_back(mk(0, I_MUL, 32'd6, 32'd7, 1, 32'd42));
    vt.push_back(mk(1, I_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'd1));
    vt.push_back(mk(0, I_DIV, 32'd9, 32'd3, 0, 32'd0));
    vt.push_back(mk(1, I_DIV, 32'd9, 32'd3, 0, 32'd0));
    vt.push_back(mk(0, I_ADD, 32'd1, 32'd2, 0, 32'd0));
`ifdef PCPI_SEQ_MUL_MULH_EN
    vt.push_back(mk(0, I_MULH, 32'h80000000, 32'h80000000, 1, 32'h40000000));
    vt.push_back(mk(0, I_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE));
    vt.push_back(mk(0, I_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF));
    vt.push_back(mk(1, I_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE));
    vt.push_back(mk(1, I_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF));
    vt.push_back(mk(1, I_MULH, 32'h80000000, 32'h80000000, 1, 32'h40000000));
`else
    vt.push_back(mk(0, I_MULH, 32'h80000000, 32'h80000000, 0, 32'd0));
    vt.push_back(mk(1, I_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'd0));
    vt.push_back(mk(1, I_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'd0));
`endif
    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = $urandom;
`ifdef PCPI_SEQ_MUL_MULH_EN
      f = 3'($urandom_range(0, 3));
`else
      f = 3'b000;
`endif
      vt.push_back(mk(k % 2,
                      {7'b0000001, 5'd2, 5'd1, f, 5'd3, 7'b0110011},
                      ra, rb, 1, model(f, ra, rb)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(b1.pcpi_ready), 32'd0);
    check("reset_wait", 32'(b1.pcpi_wait), 32'd0);
    check("reset_wr", 32'(b4.pcpi_wr), 32'd0);
    check("reset_rd", b1.pcpi_rd | b4.pcpi_rd, 32'd0);
    resetn = 1'b1;
    quiet_window(0, 5, "idle_quiet");
    check("idle_rd", b1.pcpi_rd, 32'd0);

    for (int i = 0; i < vt.size(); i++) do_op(vt[i]);

`ifdef PCPI_SEQ_MUL_MULH_EN
    abort_insn = I_MULH;
`else
    abort_insn = I_MUL;
`endif
    drive(0, 1'b1, abort_insn, 32'd11, 32'd13);
    @(posedge clk); #1;
    check("abort_wait_t1", 32'(b1.pcpi_wait), 32'd1);
    repeat (4) begin @(posedge clk); #1; end
    drive(0, 1'b0, 32'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    check("abort_wait_drop", 32'(b1.pcpi_wait), 32'd0);
    quiet_window(0, 70, "abort_no_ready");
    do_op(mk(0, I_MUL, 32'd3, 32'd5, 1, 32'd15));

    drive(0, 1'b1, I_MUL, 32'd100, 32'd200);
    repeat (10) begin @(posedge clk); #1; end
    check("pre_reset_wait", 32'(b1.pcpi_wait), 32'd1);
    resetn = 1'b0;
    #1;
    check("areset_wait", 32'(b1.pcpi_wait), 32'd0);
    check("areset_ready", 32'(b1.pcpi_ready | b1.pcpi_wr), 32'd0);
    check("areset_rd", b1.pcpi_rd, 32'd0);
    drive(0, 1'b0, 32'd0, 32'd0, 32'd0);
    #2;
    resetn = 1'b1;
    quiet_window(0, 70, "reset_no_ready");
    do_op(mk(0, I_MUL, 32'd6, 32'd7, 1, 32'd42));

    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
